// File: rtl/uart_rx_stream.sv
// uart_rx_stream: 8N1 UART receiver delivering bytes on a valid/ready stream.
// Define UART_RX_PARITY_EN to add an even-parity bit and parity_error.
module uart_rx_stream #(
    parameter int CLKS_PER_BIT = 100,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 framing_error,
    output logic                 overrun_error,
    output logic                 parity_error
);

    localparam int CNTW = $clog2(CLKS_PER_BIT);
    localparam int IDXW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNTW-1:0] HALF = CNTW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNTW-1:0] FULL = CNTW'(CLKS_PER_BIT - 1);
    localparam logic [IDXW-1:0] LAST = IDXW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        PARITY = 3'd5
`endif
    } state_t;

    state_t               state;
    state_t               state_n;
    logic                 sync1;
    logic                 rxd_s;
    logic [CNTW-1:0]      cnt;
    logic [CNTW-1:0]      cnt_n;
    logic [IDXW-1:0]      idx;
    logic [IDXW-1:0]      idx_n;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_n;
    logic                 expire;
    logic                 frame_done;
    logic                 stop_ok;
    logic                 frame_ok;

    // Preset to idle-high so reset never fakes a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxd_s <= sync1;
        end
    end

    assign expire = (cnt == '0);

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    logic par_bad_n;
`endif

    always_comb begin
        state_n    = state;
        cnt_n      = expire ? cnt : cnt - 1'b1;
        idx_n      = idx;
        shreg_n    = shreg;
        frame_done = 1'b0;
        stop_ok    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n  = par_bad;
`endif
        unique case (state)
            IDLE: begin
                if (!rxd_s) begin
                    state_n = START;
                    cnt_n   = HALF;
                end
            end
            START: begin
                if (expire) begin
                    if (!rxd_s) begin
                        state_n = DATA;
                        cnt_n   = FULL;
                        idx_n   = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (expire) begin
                    shreg_n[idx] = rxd_s;
                    cnt_n        = FULL;
                    idx_n        = idx + 1'b1;
                    if (idx == LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (expire) begin
                    par_bad_n = (^shreg) ^ rxd_s;
                    cnt_n     = FULL;
                    state_n   = STOP;
                end
            end
`endif
            STOP: begin
                if (expire) begin
                    frame_done = 1'b1;
                    stop_ok    = rxd_s;
                    state_n    = rxd_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rxd_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign frame_ok = frame_done & stop_ok & ~par_bad;

    // A bad stop bit takes priority, so parity is only flagged on a clean stop.
    always_ff @(posedge clk) begin
        if (reset) begin
            par_bad      <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            par_bad      <= par_bad_n;
            parity_error <= frame_done & stop_ok & par_bad;
        end
    end
`else
    assign frame_ok     = frame_done & stop_ok;
    assign parity_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            shreg         <= '0;
            m_data        <= '0;
            m_valid       <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            idx           <= idx_n;
            shreg         <= shreg_n;
            framing_error <= frame_done & ~stop_ok;
            overrun_error <= frame_ok & m_valid & ~m_ready;
            // Accept and reload in one cycle keeps the stream back-to-back.
            if (frame_ok && (!m_valid || m_ready)) begin
                m_data  <= shreg;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_stream.sv
// tb_uart_rx_stream: table vectors, hand sequences and a random
// frame stream checked against a byte-level model of the receiver.
module tb_uart_rx_stream;

    localparam int CPB = 16;

    logic       clk;
    logic       reset;
    logic       rxd;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       framing_error;
    logic       overrun_error;
    logic       parity_error;

    logic ready_cmd;
    logic rnd_mode;
    logic rnd_r;

    int checks;
    int errors;

    logic [7:0] rx_q[$];
    int n_ferr;
    int n_oerr;
    int n_perr;

    uart_rx_stream #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rxd(rxd),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .framing_error(framing_error),
        .overrun_error(overrun_error),
        .parity_error(parity_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign m_ready = rnd_mode ? rnd_r : ready_cmd;

    always begin
        @(posedge clk);
        #1;
        rnd_r = ($urandom_range(3) != 0);
    end

    // Observed stream: every accepted byte and every error-pulse cycle.
    always @(negedge clk) begin
        if (m_valid && m_ready) rx_q.push_back(m_data);
        if (framing_error) n_ferr++;
        if (overrun_error) n_oerr++;
        if (parity_error) n_perr++;
    end

    typedef struct {
        logic [7:0] data;
        bit         stop;
        bit         pflip;
        bit         exp_v;
        bit         exp_f;
        bit         exp_p;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     nm, act, act, exp, exp);
        end
    endtask

    task automatic hold(input logic b, input int n);
        rxd = b;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop,
                              input bit pflip);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(d[i], CPB);
`ifdef UART_RX_PARITY_EN
        hold((^d) ^ pflip, CPB);
`endif
        hold(stop, CPB);
    endtask

    int b_rx, b_f, b_o, b_p;

    task automatic snap();
        b_rx = rx_q.size();
        b_f  = n_ferr;
        b_o  = n_oerr;
        b_p  = n_perr;
    endtask

    initial begin
        logic [7:0] exp_q[$];
        int         e_f;
        int         e_p;
        int         nrx;

        checks    = 0;
        errors    = 0;
        n_ferr    = 0;
        n_oerr    = 0;
        n_perr    = 0;
        rxd       = 1'b1;
        reset     = 1'b1;
        ready_cmd = 1'b1;
        rnd_mode  = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;

        check("rst_valid", int'(m_valid), 0);
        check("rst_data", int'(m_data), 0);
        check("rst_ferr", int'(framing_error), 0);
        check("rst_oerr", int'(overrun_error), 0);
        check("rst_perr", int'(parity_error), 0);
        hold(1'b1, 2 * CPB);

        // Glitch shorter than half a bit.
        snap();
        hold(1'b0, 4);
        hold(1'b1, 3 * CPB);
        check("glitch_rx", rx_q.size() - b_rx, 0);
        check("glitch_ferr", n_ferr - b_f, 0);
        check("glitch_valid", int'(m_valid), 0);

        tbl.push_back('{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
`ifdef UART_RX_PARITY_EN
        tbl.push_back('{8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
`endif
        foreach (tbl[k]) begin
            snap();
            send_frame(tbl[k].data, tbl[k].stop, tbl[k].pflip);
            hold(1'b1, 2 * CPB);
            check("tbl_rx", rx_q.size() - b_rx, int'(tbl[k].exp_v));
            if (tbl[k].exp_v && rx_q.size() > 0)
                check("tbl_data", int'(rx_q[rx_q.size() - 1]),
                      int'(tbl[k].data));
            check("tbl_ferr", n_ferr - b_f, int'(tbl[k].exp_f));
            check("tbl_perr", n_perr - b_p, int'(tbl[k].exp_p));
            check("tbl_oerr", n_oerr - b_o, 0);
        end

        // Back-to-back frames, no idle between stop and start.
        snap();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        hold(1'b1, 2 * CPB);
        check("b2b_rx", rx_q.size() - b_rx, 2);
        if (rx_q.size() >= b_rx + 2) begin
            check("b2b_first", int'(rx_q[b_rx]), 8'h00);
            check("b2b_second", int'(rx_q[b_rx+1]), 8'hFF);
        end

        // Bad stop then a long break.
        snap();
        send_frame(8'h3C, 1'b0, 1'b0);
        hold(1'b0, 40 * CPB);
        hold(1'b1, 2 * CPB);
        check("brk_ferr", n_ferr - b_f, 1);
        check("brk_rx", rx_q.size() - b_rx, 0);
        send_frame(8'h55, 1'b1, 1'b0);
        hold(1'b1, 2 * CPB);
        check("brk_after_rx", rx_q.size() - b_rx, 1);
        if (rx_q.size() > b_rx)
            check("brk_after_data", int'(rx_q[b_rx]), 8'h55);

        // Overrun with the consumer stalled.
        snap();
        ready_cmd = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        hold(1'b1, CPB);
        check("ovr_valid1", int'(m_valid), 1);
        check("ovr_data1", int'(m_data), 8'h11);
        send_frame(8'h22, 1'b1, 1'b0);
        hold(1'b1, CPB);
        check("ovr_valid2", int'(m_valid), 1);
        check("ovr_hold_data", int'(m_data), 8'h11);
        check("ovr_pulse", n_oerr - b_o, 1);
        check("ovr_ferr", n_ferr - b_f, 0);
        ready_cmd = 1'b1;
        hold(1'b1, 3);
        check("ovr_drain_valid", int'(m_valid), 0);
        check("ovr_drain_rx", rx_q.size() - b_rx, 1);
        if (rx_q.size() > b_rx)
            check("ovr_drain_data", int'(rx_q[b_rx]), 8'h11);

        // Reset in the middle of data bit 3 of 0x81.
        snap();
        hold(1'b0, CPB);
        hold(1'b1, CPB);
        hold(1'b0, CPB);
        hold(1'b0, CPB);
        hold(1'b0, CPB / 2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rxd   = 1'b1;
        check("mid_rst_valid", int'(m_valid), 0);
        check("mid_rst_data", int'(m_data), 0);
        hold(1'b1, 4 * CPB);
        check("mid_rst_rx", rx_q.size() - b_rx, 0);
        check("mid_rst_ferr", n_ferr - b_f, 0);
        send_frame(8'h7E, 1'b1, 1'b0);
        hold(1'b1, 2 * CPB);
        check("mid_rst_next_rx", rx_q.size() - b_rx, 1);
        if (rx_q.size() > b_rx)
            check("mid_rst_next_data", int'(rx_q[b_rx]), 8'h7E);

        // Random frames; model: good frames arrive in order, bad ones counted.
        snap();
        e_f      = 0;
        e_p      = 0;
        rnd_mode = 1'b1;
        for (int i = 0; i < 30; i++) begin
            logic [7:0] d;
            bit         bad;
            bit         pb;
            int         gap;
            d   = 8'($urandom);
            bad = ($urandom_range(7) == 0);
            pb  = 1'b0;
`ifdef UART_RX_PARITY_EN
            pb  = ($urandom_range(7) == 0);
`endif
            gap = bad ? 1 + $urandom_range(1) : $urandom_range(2);
            send_frame(d, !bad, pb);
            hold(1'b1, gap * CPB);
            if (bad) e_f++;
            else if (pb) e_p++;
            else exp_q.push_back(d);
        end
        hold(1'b1, 3 * CPB);
        rnd_mode = 1'b0;
        nrx = rx_q.size() - b_rx;
        check("rnd_count", nrx, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < nrx; i++)
            check("rnd_data", int'(rx_q[b_rx+i]), int'(exp_q[i]));
        check("rnd_ferr", n_ferr - b_f, e_f);
        check("rnd_perr", n_perr - b_p, e_p);
        check("rnd_oerr", n_oerr - b_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
